// File: rtl/wb_tt_pkg.sv
// Shared definitions for the Tiny Tapeout mux controller.
// Contents:
//   - byte offsets of the Wishbone register window
//   - bit positions inside CTRL
//   - design-clock FSM state encoding
//   - lane_mask(): expands Wishbone byte enables into a 32-bit write mask
package wb_tt_pkg;

  localparam logic [7:0] REG_CTRL       = 8'h00;
  localparam logic [7:0] REG_DESIGN_SEL = 8'h04;
  localparam logic [7:0] REG_CLK_DIV    = 8'h08;
  localparam logic [7:0] REG_IN_DATA    = 8'h0C;
  localparam logic [7:0] REG_OUT_DATA   = 8'h10;
  localparam logic [7:0] REG_CYCLE_CNT  = 8'h14;
  localparam logic [7:0] REG_STATUS     = 8'h18;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_MANUAL = 1;
  localparam int CTRL_STEP   = 2;

  typedef enum logic [1:0] {
    CLK_OFF     = 2'd0,
    CLK_RUN     = 2'd1,
    CLK_STEP_HI = 2'd2
  } clk_state_e;

  function automatic logic [31:0] lane_mask(input logic [3:0] sel);
    lane_mask = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction

endpackage

// File: rtl/wb_tt_ctrl_clk_gen.sv
// Design clock generator for the Tiny Tapeout mux.
// Modes:
//   - free-running divided clock
//   - single-step pulses
// Also counts rising edges of the generated clock.
// Ports:
//   clk_i, rst_n_i      system clock, asynchronous active-low reset
//   en_i, manual_i      CTRL.EN / CTRL.MANUAL (registered copies)
//   step_i              one-cycle STEP request, coincident with the write
//   cnt_clr_i           one-cycle CYCLE_CNT clear (wins over an increment)
//   div_i               half-period length minus one, in clk_i cycles
//   tt_clk_o            generated design clock
//   step_busy_o         high while a single-step pulse is being driven
//   cycle_cnt_o         number of 0->1 transitions of tt_clk_o (wraps)
module tt_clk_gen
  import wb_tt_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        en_i,
  input  logic        manual_i,
  input  logic        step_i,
  input  logic        cnt_clr_i,
  input  logic [15:0] div_i,
  output logic        tt_clk_o,
  output logic        step_busy_o,
  output logic [31:0] cycle_cnt_o
);

  clk_state_e  state_q;
  logic        clk_q;
  logic        busy_q;
  logic [15:0] div_cnt_q;
  logic [31:0] cyc_q;

  logic step_go;
  logic tick;
  logic rise;

  // A step is accepted only from an idle-manual clock that is low.
  // The divider compares with >= so that lowering div_i below the
  // running count toggles on the next cycle instead of wrapping.
  always_comb begin
    step_go = en_i && manual_i && step_i && !clk_q && (state_q != CLK_STEP_HI);
    tick    = en_i && !manual_i && (state_q == CLK_RUN) && (div_cnt_q >= div_i);
    rise    = step_go || (tick && !clk_q);
  end

  // Idle-manual shares the RUN encoding; MANUAL suppresses counting and
  // holds the clock low there, which also forces a high clock low when
  // switching from free-running to manual.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= CLK_OFF;
      clk_q     <= 1'b0;
      busy_q    <= 1'b0;
      div_cnt_q <= '0;
    end else if (!en_i) begin
      state_q   <= CLK_OFF;
      clk_q     <= 1'b0;
      busy_q    <= 1'b0;
      div_cnt_q <= '0;
    end else if (state_q == CLK_STEP_HI) begin
      state_q   <= CLK_RUN;
      clk_q     <= 1'b0;
      busy_q    <= 1'b0;
      div_cnt_q <= '0;
    end else if (manual_i) begin
      div_cnt_q <= '0;
      if (step_go) begin
        state_q <= CLK_STEP_HI;
        clk_q   <= 1'b1;
        busy_q  <= 1'b1;
      end else begin
        state_q <= CLK_RUN;
        clk_q   <= 1'b0;
      end
    end else if (state_q == CLK_OFF) begin
      state_q   <= CLK_RUN;
      clk_q     <= 1'b0;
      div_cnt_q <= '0;
    end else if (tick) begin
      clk_q     <= !clk_q;
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cyc_q <= '0;
    end else if (cnt_clr_i) begin
      cyc_q <= '0;
    end else if (rise) begin
      cyc_q <= cyc_q + 32'd1;
    end
  end

  assign tt_clk_o    = clk_q;
  assign step_busy_o = busy_q;
  assign cycle_cnt_o = cyc_q;

endmodule

// File: rtl/wb_tt_ctrl.sv
// Wishbone responder that lets management firmware drive the Tiny Tapeout
// mux (design select, input data, design clock) and read outputs back.
// Ports:
//   wb_clk_i, wb_rst_n_i      clock, asynchronous active-low reset
//   wbs_*                     Wishbone classic slave (registered 1-cycle ack)
//   tt_sel_o, tt_sel_load_o   design index and one-cycle load pulse
//   tt_in_o                   design inputs (zero while CTRL.EN=0)
//   tt_clk_o                  generated design clock
//   tt_out_i                  design outputs, asynchronous, synchronised here
module wb_tt_ctrl #(
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter logic [15:0] DEFAULT_DIV = 16'd4,
  parameter int          SEL_W       = 9,
  parameter int          IO_W        = 8
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_n_i,
  input  logic             wbs_stb_i,
  input  logic             wbs_cyc_i,
  input  logic             wbs_we_i,
  input  logic [3:0]       wbs_sel_i,
  input  logic [31:0]      wbs_adr_i,
  input  logic [31:0]      wbs_dat_i,
  output logic             wbs_ack_o,
  output logic [31:0]      wbs_dat_o,
  output logic [SEL_W-1:0] tt_sel_o,
  output logic             tt_sel_load_o,
  output logic [IO_W-1:0]  tt_in_o,
  output logic             tt_clk_o,
  input  logic [IO_W-1:0]  tt_out_i
);
  import wb_tt_pkg::*;

  logic             ack_q;
  logic [31:0]      dat_q, dat_d;
  logic [5:0]       req_off_q;
  logic             req_we_q;
  logic [3:0]       req_sel_q;
  logic [31:0]      req_dat_q;
  logic [1:0]       ctrl_q;
  logic [SEL_W-1:0] sel_q;
  logic [15:0]      div_q;
  logic [IO_W-1:0]  in_q;
  logic             sel_load_q;
  logic [IO_W-1:0]  out_meta_q, out_sync_q;

  logic             tt_clk, step_busy;
  logic [31:0]      cycle_cnt;

  logic             in_win, req, wr_fire, step_pulse, cnt_clr;
  logic [7:0]       wr_off;
  logic [31:0]      wmask, sel_wr, div_wr, in_wr;
  logic             unused_bits;

  assign in_win  = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  // !ack_q forces alternate-cycle acks when the master holds stb.
  assign req     = wbs_stb_i && wbs_cyc_i && in_win && !ack_q;
  // The request is captured when it is accepted and committed on the ack
  // cycle, so the master may drop stb as soon as it sees ack.
  assign wr_fire = ack_q && req_we_q;
  assign wr_off  = {req_off_q, 2'b00};
  assign wmask   = lane_mask(req_sel_q);
  assign sel_wr  = (32'(sel_q) & ~wmask) | (req_dat_q & wmask);
  assign div_wr  = (32'(div_q) & ~wmask) | (req_dat_q & wmask);
  assign in_wr   = (32'(in_q)  & ~wmask) | (req_dat_q & wmask);

  assign step_pulse = wr_fire && (wr_off == REG_CTRL) && req_sel_q[0]
                      && req_dat_q[CTRL_STEP];
  assign cnt_clr    = wr_fire && (wr_off == REG_CYCLE_CNT);

  always_comb begin
    dat_d = '0;
    if (req) begin
      case ({wbs_adr_i[7:2], 2'b00})
        REG_CTRL:       dat_d = 32'(ctrl_q);
        REG_DESIGN_SEL: dat_d = 32'(sel_q);
        REG_CLK_DIV:    dat_d = 32'(div_q);
        REG_IN_DATA:    dat_d = 32'(in_q);
        REG_OUT_DATA:   dat_d = 32'(out_sync_q);
        REG_CYCLE_CNT:  dat_d = cycle_cnt;
        REG_STATUS:     dat_d = {30'd0, step_busy, tt_clk};
        default:        dat_d = '0;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      ack_q      <= 1'b0;
      dat_q      <= '0;
      req_off_q  <= '0;
      req_we_q   <= 1'b0;
      req_sel_q  <= '0;
      req_dat_q  <= '0;
      ctrl_q     <= '0;
      sel_q      <= '0;
      div_q      <= DEFAULT_DIV;
      in_q       <= '0;
      sel_load_q <= 1'b0;
      out_meta_q <= '0;
      out_sync_q <= '0;
    end else begin
      ack_q      <= req;
      dat_q      <= dat_d;
      sel_load_q <= wr_fire && (wr_off == REG_DESIGN_SEL);
      out_meta_q <= tt_out_i;
      out_sync_q <= out_meta_q;
      if (req) begin
        req_off_q <= wbs_adr_i[7:2];
        req_we_q  <= wbs_we_i;
        req_sel_q <= wbs_sel_i;
        req_dat_q <= wbs_dat_i;
      end
      if (wr_fire) begin
        case (wr_off)
          REG_CTRL: begin
            if (req_sel_q[0]) begin
              ctrl_q[CTRL_EN]     <= req_dat_q[CTRL_EN];
              ctrl_q[CTRL_MANUAL] <= req_dat_q[CTRL_MANUAL];
            end
          end
          REG_DESIGN_SEL: sel_q <= sel_wr[SEL_W-1:0];
          REG_CLK_DIV:    div_q <= div_wr[15:0];
          REG_IN_DATA:    in_q  <= in_wr[IO_W-1:0];
          default: ;
        endcase
      end
    end
  end

  tt_clk_gen u_clk_gen (
    .clk_i       (wb_clk_i),
    .rst_n_i     (wb_rst_n_i),
    .en_i        (ctrl_q[CTRL_EN]),
    .manual_i    (ctrl_q[CTRL_MANUAL]),
    .step_i      (step_pulse),
    .cnt_clr_i   (cnt_clr),
    .div_i       (div_q),
    .tt_clk_o    (tt_clk),
    .step_busy_o (step_busy),
    .cycle_cnt_o (cycle_cnt)
  );

  assign wbs_ack_o     = ack_q;
  assign wbs_dat_o     = dat_q;
  assign tt_sel_o      = sel_q;
  assign tt_sel_load_o = sel_load_q;
  assign tt_in_o       = ctrl_q[CTRL_EN] ? in_q : '0;
  assign tt_clk_o      = tt_clk;

  // Word-aligned decode ignores adr[1:0]; merge results wider than the
  // register they feed are discarded.
  assign unused_bits = ^{wbs_adr_i[1:0], sel_wr[31:SEL_W], div_wr[31:16],
                         in_wr[31:IO_W]};

endmodule
